channel_fifo: RTL and testbench
===============================

// Module: channel_fifo
// PURPOSE
//  Elastic buffer between a Channel producer and a Channel consumer (v/d from sender, a from receiver).
//  Decouples upstream stages (e.g. RandomChannelSrc in benches, encoder/router logic in RTL) from downstream stall patterns.
//  Sustains one transfer per clk in and out simultaneously; no combinational path from out.a to in.a.
// PARAMETERS
//  N      8  data width of in.d / out.d (bits)
//  Depth  4  storage entries; power of 2, >= 2
// PORTS
//  clk       input   1          single clock; all state on posedge
//  reset     input   1          asynchronous, active-low; asserts immediately, release synchronous to clk
//  in.d      input   N          upstream data, valid while in.v=1
//  in.v      input   1          upstream valid
//  in.a      output  1          upstream acknowledge; in.v & in.a at posedge = push
//  out.d     output  N          downstream data = head entry
//  out.v     output  1          downstream valid = FIFO not empty
//  out.a     input   1          downstream acknowledge; out.v & out.a at posedge = pop
//  hwm       output  clog2(Depth)+1  peak occupancy since reset (only with CHANNEL_FIFO_HWM_EN)
// BEHAVIOUR
//  - Reset (reset=0): wr_ptr=rd_ptr=0, count=0, in.a=1, out.v=0, out.d=0, hwm=0; storage contents not cleared.
//  - Reset mid-operation: all in-flight entries discarded; no transfer counted on the reset edge.
//  - in.a = (count != Depth), driven from registered count only; out.v = (count != 0); out.d = mem[rd_ptr].
//  - push = in.v & in.a; pop = out.v & out.a; both sampled at posedge clk.
//  - push: mem[wr_ptr] <= in.d, wr_ptr <= wr_ptr+1 (wraps modulo Depth, ptr width clog2(Depth)).
//  - pop: rd_ptr <= rd_ptr+1 (wraps modulo Depth).
//  - count (width clog2(Depth)+1): push&!pop +1; pop&!push -1; push&pop unchanged; never <0 or >Depth.
//  - Latency: word pushed at edge k is on out.d with out.v=1 after edge k (available for pop at edge k+1); no bypass.
//  - Empty + push: count 0->1, out.v rises next cycle; simultaneous pop impossible (out.v=0).
//  - Full: in.a=0, push blocked even if out.a=1 same cycle (no pass-through); in.a rises cycle after a pop.
//  - Full + pop: count Depth->Depth-1, no data lost.
//  - Ordering strictly FIFO; in.d ignored when in.v=0; out.d undefined-content but stable when out.v=0.
//  - Sender must hold in.v/in.d until acknowledged; block never drops or duplicates a word.
// CONFIGURATION
//  CHANNEL_FIFO_HWM_EN defined: hwm port present; hwm <= max(hwm, next count) every cycle; cleared only by reset.
//  CHANNEL_FIFO_HWM_EN undefined: hwm port and register omitted; datapath behaviour identical.
// STRUCTURE
//  - channel_pkg: function clog2-based widths (PtrW(Depth), CntW(Depth)); typedefs for pointer/count per instance via localparam.
//  - Sub-module channel_fifo_mem: Depth x N register array, one write port (we, waddr, wdata), one async read port (raddr, rdata).
//  - channel_fifo top: pointers, count, handshake outputs, optional hwm; parameter check via initial assertion (Depth power of 2, >=2).
// TESTING
//  - Reset: hold reset=0 3 cycles with in.v=1 -> in.a=1, out.v=0, hwm=0; no push after release until first posedge.
//  - Fill: N=8,Depth=4, out.a=0, push 0x11,0x22,0x33,0x44 -> in.a=0 after 4th edge, 0x55 held off; count=4.
//  - Drain order: then out.a=1 -> out.d sequence 0x11,0x22,0x33,0x44,0x55 one per cycle; out.v=0 after last.
//  - Streaming: in.v=1,out.a=1 continuous, 1000 words incrementing -> 1 word/cycle after 1-cycle startup, count stays 1.
//  - Full simultaneous: count=4, in.v=1,out.a=1 -> pop only that edge, count=3, in.a=1 next cycle.
//  - Random: RandomChannelSrc + ChannelSink delays 0..5 with scoreboard, 10k words -> zero mismatches; HWM_EN build hwm<=4 and equals max observed count.

Source files
------------

// File: rtl/channel_pkg.sv
// Width helpers shared by the channel FIFO and its storage array.
package channel_pkg;

  function automatic int PtrW(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int CntW(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// Depth x N register array: one synchronous write port, one asynchronous read port.
module channel_fifo_mem #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  // Storage is deliberately not reset; occupancy tracking makes stale entries unobservable.
  logic [DEPTH-1:0][N-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/channel_fifo.sv
// Elastic valid/ack channel buffer; in_a_o depends only on registered count (no out_a_i -> in_a_o path).
// Optional peak-occupancy output hwm_o when CHANNEL_FIFO_HWM_EN is defined.
module channel_fifo
  import channel_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             in_d_i,
  input  logic                     in_v_i,
  output logic                     in_a_o,
  output logic [N-1:0]             out_d_o,
  output logic                     out_v_o,
  input  logic                     out_a_i
`ifdef CHANNEL_FIFO_HWM_EN
  ,
  output logic [CntW(DEPTH)-1:0]   hwm_o
`endif
);

  localparam int PW = PtrW(DEPTH);
  localparam int CW = CntW(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL_C = cnt_t'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("channel_fifo: DEPTH must be a power of 2 and >= 2");
  end

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   cnt_q, cnt_d;
  logic   push, pop;
  logic [N-1:0] rdata;

  assign in_a_o  = (cnt_q != FULL_C);
  assign out_v_o = (cnt_q != '0);
  assign push    = in_v_i & in_a_o;
  assign pop     = out_v_o & out_a_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (push && !pop)      cnt_d = cnt_q + cnt_t'(1);
    else if (pop && !push) cnt_d = cnt_q - cnt_t'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  channel_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_d_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Masked while empty so the output is a clean zero out of reset.
  assign out_d_o = out_v_o ? rdata : '0;

`ifdef CHANNEL_FIFO_HWM_EN
  cnt_t hwm_q, hwm_d;

  assign hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Directed + randomized scoreboard bench for channel_fifo (N=8, DEPTH=4).
module tb_channel_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_d;
  logic       in_v;
  logic       in_a;
  logic [7:0] out_d;
  logic       out_v;
  logic       out_a;
`ifdef CHANNEL_FIFO_HWM_EN
  logic [2:0] hwm;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  channel_fifo #(.N(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_d_i  (in_d),
    .in_v_i  (in_v),
    .in_a_o  (in_a),
    .out_d_o (out_d),
    .out_v_o (out_v),
    .out_a_i (out_a)
`ifdef CHANNEL_FIFO_HWM_EN
    ,
    .hwm_o   (hwm)
`endif
  );

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_v = 1'b0; out_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] w);
    in_v = 1'b1; in_d = w;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_v = 1'b1; in_d = 8'hAA; out_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({in_a, out_v, out_d} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_state: in_a/out_v/out_d=%b/%b/%h want 1/0/00", in_a, out_v, out_d);
    end
`ifdef CHANNEL_FIFO_HWM_EN
    n_chk++;
    if (hwm !== 3'd0) begin n_fail++; $display("FAIL reset_hwm: got %0d want 0", hwm); end
`endif
    @(posedge clk); #1 reset = 1'b1;
    #2;
    n_chk++;
    if (out_v !== 1'b0) begin n_fail++; $display("FAIL release_no_push: out_v=%b want 0", out_v); end
    @(posedge clk); #1;
    n_chk++;
    if ({out_v, out_d} !== {1'b1, 8'hAA}) begin
      n_fail++; $display("FAIL first_push: out_v/out_d=%b/%h want 1/aa", out_v, out_d);
    end
    in_v = 1'b0;
    do_reset();
  endtask

  task automatic test_fill();
    out_a = 1'b0;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    in_v = 1'b1; in_d = 8'h55;
    n_chk++;
    if ({in_a, out_v, out_d} !== {1'b0, 1'b1, 8'h11}) begin
      n_fail++; $display("FAIL fill_full: in_a/out_v/out_d=%b/%b/%h want 0/1/11", in_a, out_v, out_d);
    end
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if ({in_a, out_d} !== {1'b0, 8'h11}) begin
      n_fail++; $display("FAIL fill_holdoff: in_a/out_d=%b/%h want 0/11", in_a, out_d);
    end
`ifdef CHANNEL_FIFO_HWM_EN
    n_chk++;
    if (hwm !== 3'd4) begin n_fail++; $display("FAIL fill_hwm: got %0d want 4", hwm); end
`endif
  endtask

  task automatic test_drain();
    logic [7:0] exp [5];
    logic pushed;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h55;
    out_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({out_v, out_d} !== {1'b1, exp[i]}) begin
        n_fail++; $display("FAIL drain_%0d: out_v/out_d=%b/%h want 1/%h", i, out_v, out_d, exp[i]);
      end
      pushed = in_v & in_a;
      @(posedge clk); #1;
      if (pushed) in_v = 1'b0;
    end
    n_chk++;
    if ({out_v, in_a} !== 2'b01) begin
      n_fail++; $display("FAIL drain_empty: out_v/in_a=%b/%b want 0/1", out_v, in_a);
    end
    out_a = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    in_v = 1'b1; out_a = 1'b1; in_d = 8'h00;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({out_v, in_a, out_d} !== {2'b11, 8'(k)}) begin
        n_fail++; $display("FAIL stream_%0d: out_v/in_a/out_d=%b/%b/%h want 1/1/%h", k, out_v, in_a, out_d, 8'(k));
      end
      in_d = 8'(k + 1);
    end
    in_v = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (out_v !== 1'b0) begin n_fail++; $display("FAIL stream_end: out_v=%b want 0", out_v); end
    out_a = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [7:0] exp [4];
    exp[0] = 8'hA2; exp[1] = 8'hA3; exp[2] = 8'hA4; exp[3] = 8'hA5;
    do_reset();
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
    in_v = 1'b1; in_d = 8'hA5; out_a = 1'b1;
    n_chk++;
    if (in_a !== 1'b0) begin n_fail++; $display("FAIL fs_full: in_a=%b want 0", in_a); end
    @(posedge clk); #1;
    n_chk++;
    if ({in_a, out_v, out_d} !== {2'b11, 8'hA2}) begin
      n_fail++; $display("FAIL fs_pop_only: in_a/out_v/out_d=%b/%b/%h want 1/1/a2", in_a, out_v, out_d);
    end
    out_a = 1'b0;
    @(posedge clk); #1;
    in_v = 1'b0;
    n_chk++;
    if ({in_a, out_d} !== {1'b0, 8'hA2}) begin
      n_fail++; $display("FAIL fs_refull: in_a/out_d=%b/%h want 0/a2", in_a, out_d);
    end
    out_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({out_v, out_d} !== {1'b1, exp[i]}) begin
        n_fail++; $display("FAIL fs_drain_%0d: out_v/out_d=%b/%h want 1/%h", i, out_v, out_d, exp[i]);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (out_v !== 1'b0) begin n_fail++; $display("FAIL fs_empty: out_v=%b want 0", out_v); end
    out_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(8'h66); push_word(8'h77);
    in_v = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({out_v, in_a, out_d} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL reset_mid: out_v/in_a/out_d=%b/%b/%h want 0/1/00", out_v, in_a, out_d);
    end
`ifdef CHANNEL_FIFO_HWM_EN
    n_chk++;
    if (hwm !== 3'd0) begin n_fail++; $display("FAIL reset_mid_hwm: got %0d want 0", hwm); end
`endif
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp;
    int sent, rcvd, cyc, mc, maxc, src_dly, snk_dly;
    logic push, pop;
    do_reset();
    sent = 0; rcvd = 0; cyc = 0; mc = 0; maxc = 0;
    src_dly = $urandom_range(0, 5); snk_dly = $urandom_range(0, 5);
    while (rcvd < 10000 && cyc < 60000) begin
      @(negedge clk);
      n_chk++;
      if ({in_a, out_v} !== {mc != 4, mc != 0}) begin
        n_fail++; $display("FAIL rnd_flags cyc %0d: in_a/out_v=%b/%b model count %0d", cyc, in_a, out_v, mc);
      end
      push = in_v & in_a;
      pop  = out_v & out_a;
      if (pop) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_underflow cyc %0d: pop with empty scoreboard, out_d=%h", cyc, out_d);
        end else begin
          exp = q.pop_front();
          if (out_d !== exp) begin
            n_fail++; $display("FAIL rnd_data word %0d: out_d=%h want %h", rcvd, out_d, exp);
          end
        end
        rcvd++;
      end
      if (push) begin q.push_back(in_d); sent++; end
      mc = mc + (push ? 1 : 0) - (pop ? 1 : 0);
      if (mc > maxc) maxc = mc;
      @(posedge clk); #1;
      if (push) in_v = 1'b0;
      if (!in_v && sent < 10000) begin
        if (src_dly == 0) begin
          in_v = 1'b1; in_d = 8'($urandom); src_dly = $urandom_range(0, 5);
        end else src_dly--;
      end
      if (snk_dly == 0) begin out_a = 1'b1; snk_dly = $urandom_range(0, 5); end
      else begin out_a = 1'b0; snk_dly--; end
      cyc++;
    end
    in_v = 1'b0; out_a = 1'b0;
    n_chk++;
    if (rcvd != 10000 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd_complete: received %0d want 10000, left %0d want 0", rcvd, q.size());
    end
`ifdef CHANNEL_FIFO_HWM_EN
    n_chk++;
    if (hwm !== 3'(maxc) || maxc > 4) begin
      n_fail++; $display("FAIL rnd_hwm: got %0d want %0d (<=4)", hwm, maxc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
